sram_bank_arbiter: RTL
======================

Name: sram_bank_arbiter

Overview:
- Shares one SramBank between NUM_REQ requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. One access is in flight at a time.
- All bank-side signals come straight from flops, so the bank's WrEn is glitch-free. Read data is captured into a response register.

Parameters:
- WIDTH, 8, data word width; must match the SramBank it drives.
- DEPTH, 512, number of bank words.
- ADDR_BITS, $clog2(DEPTH), bank address width.
- NUM_REQ, 2, number of requesters (2..8).
- ID_BITS, max(1,$clog2(NUM_REQ)), width of the grant index.

Ports:
- Clk  in  1  rising-edge clock.
- RstN  in  1  asynchronous active-low reset.
- ReqValid  in  NUM_REQ  per-requester request valid.
- ReqReady  out  NUM_REQ  per-requester request accept; one-hot or zero.
- ReqWrEn  in  NUM_REQ  1 = write, 0 = read; one bit per requester.
- ReqAddr  in  NUM_REQ*ADDR_BITS  packed addresses; requester i at slice [i*ADDR_BITS +: ADDR_BITS].
- ReqWrData  in  NUM_REQ*WIDTH  packed write data.
- RspValid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- RspReady  in  NUM_REQ  per-requester response accept.
- RspData  out  WIDTH  read data; for a write, the data that was written.
- BankAddr  out  ADDR_BITS  to SramBank Addr.
- BankWrData  out  WIDTH  to SramBank WrData.
- BankWrEn  out  1  to SramBank WrEn.
- BankRdData  in  WIDTH  from SramBank RdData.

Behaviour:
- Reset (RstN low, asynchronous):
  - State = IDLE, round-robin pointer = 0.
  - ReqReady, RspValid, BankWrEn, BankAddr, BankWrData and RspData all = 0.
  - An access in progress is abandoned: no bank write completes and no response is issued.
- State IDLE:
  - Search ReqValid starting at the pointer, wrapping modulo NUM_REQ. The first set bit wins.
  - ReqReady[winner] = 1 combinationally in the same cycle. The handshake completes on that edge.
  - At the edge, latch the winner's Addr, WrData, WrEn and index into the bank flops (BankAddr, BankWrData, BankWrEn = latched WrEn). Set pointer = (winner+1) mod NUM_REQ. Go to ACCESS.
  - If no ReqValid bit is set, stay in IDLE. BankWrEn = 0.
- State ACCESS (exactly one cycle):
  - The bank sees a stable address, plus WrEn/WrData for a write.
  - At the edge: RspData <= BankRdData (for a write, SramBank returns WrData). BankWrEn <= 0. BankAddr and BankWrData hold. Go to RESP.
- State RESP:
  - RspValid[id] = 1 and RspData held.
  - When RspReady[id] = 1, RspValid drops at the next edge and the state goes to IDLE.
  - RspReady bits of other requesters are ignored.
  - ReqReady = 0 in ACCESS and RESP.
- Latency and throughput:
  - From request accept to RspValid: 2 edges.
  - With RspReady tied high, peak throughput is one access per 3 cycles.
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0.
  - A requester waits at most NUM_REQ-1 grants.
- Boundary conditions:
  - A requester that deasserts ReqValid before being granted is simply skipped; there is no penalty.
  - A requester may hold ReqValid high while its own response is pending. It is not re-granted until IDLE.
  - Addresses DEPTH-1 and 0 need no special handling. Any ADDR_BITS value is passed through as-is.
  - BankWrEn is never 1 outside ACCESS.

Decomposition:
- Package sram_arb_pkg:
  - State enum: IDLE, ACCESS, RESP (2 bits).
  - Helper function next_rr_winner(valid, ptr) returning {found, idx}.
  - ID_BITS computation.
- One sub-module, rr_arbiter: combinational round-robin winner plus a registered pointer, with an Advance input. It is reusable for other bank arbiters.
- Verification instantiates SramBank behind this block.

Test Plan:
- Single read. Preload addr 0x05 = 0xA5. Requester 0 reads 0x05 → ReqReady[0] in cycle 0, BankWrEn stays 0, RspValid[0] at edge 2 with RspData = 0xA5.
- Write then read. Requester 1 writes 0x3C to addr 0x1FF, then reads 0x1FF → BankWrEn high for exactly one cycle; write response RspData = 0x3C; read returns 0x3C.
- Contention. Both ReqValid held high with RspReady = 1 → grant order 0,1,0,1. Each requester is granted every 6 cycles.
- Response backpressure. Hold RspReady[0] = 0 for 5 cycles → RspValid[0] and RspData stable. Requester 1's request is not accepted until the cycle after RspReady[0] rises.
- Reset mid-access. Assert RstN low during ACCESS of a write to 0x10 (old value 0x00) → all outputs 0 immediately, no RspValid after reset. A read of 0x10 returns either 0x00 or the new data, never X, and must match the scoreboard's prediction of whether the write edge was reached.
- Skipped requester. ReqValid[1] pulses for one cycle while requester 0 is being serviced → no grant to 1, pointer unchanged, no response on RspValid[1].

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM bank arbiter and its round-robin picker.
package sram_arb_pkg;

  localparam int unsigned MaxReq    = 8;
  localparam int unsigned MaxIdBits = 3;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MaxIdBits-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned calc_id_bits(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // First set bit of valid searching upward from ptr, wrapping modulo num_req.
  function automatic rr_pick_t next_rr_winner(input logic [MaxReq-1:0]    valid,
                                              input logic [MaxIdBits-1:0] ptr,
                                              input int unsigned          num_req);
    rr_pick_t    pick;
    int unsigned cand;
    pick = '0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      cand = (32'(ptr) + k) % num_req;
      if (k < num_req && !pick.found && valid[cand[MaxIdBits-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = cand[MaxIdBits-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select with a registered priority pointer that moves past
// the winner whenever advance is asserted.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_BITS = calc_id_bits(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic               found,
  output logic [ID_BITS-1:0] winner
);

  logic [ID_BITS-1:0] ptr_q;
  rr_pick_t           pick;

  always_comb begin
    pick   = next_rr_winner(MaxReq'(valid), MaxIdBits'(ptr_q), NUM_REQ);
    found  = pick.found;
    winner = ID_BITS'(pick.idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && found) begin
      ptr_q <= (32'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Shares one SRAM bank between NUM_REQ requesters, one access in flight at a time.
// All bank-facing signals are flops so the bank write enable never glitches.
module sram_bank_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH),
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ID_BITS   = calc_id_bits(NUM_REQ)
) (
  input  logic                         Clk,
  input  logic                         RstN,
  input  logic [NUM_REQ-1:0]           ReqValid,
  output logic [NUM_REQ-1:0]           ReqReady,
  input  logic [NUM_REQ-1:0]           ReqWrEn,
  input  logic [NUM_REQ*ADDR_BITS-1:0] ReqAddr,
  input  logic [NUM_REQ*WIDTH-1:0]     ReqWrData,
  output logic [NUM_REQ-1:0]           RspValid,
  input  logic [NUM_REQ-1:0]           RspReady,
  output logic [WIDTH-1:0]             RspData,
  output logic [ADDR_BITS-1:0]         BankAddr,
  output logic [WIDTH-1:0]             BankWrData,
  output logic                         BankWrEn,
  input  logic [WIDTH-1:0]             BankRdData
);

  arb_state_e         state_q;
  logic [ID_BITS-1:0] id_q;
  logic               found;
  logic [ID_BITS-1:0] winner;
  logic               grant;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [WIDTH-1:0]     sel_wdata;
  logic                 sel_we;

  assign grant = (state_q == StIdle) && found;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_BITS(ID_BITS)
  ) u_rr (
    .clk    (Clk),
    .rst_n  (RstN),
    .valid  (ReqValid),
    .advance(grant),
    .found  (found),
    .winner (winner)
  );

  always_comb begin
    ReqReady  = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    if (grant) begin
      ReqReady[winner] = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(winner) == i) begin
        sel_addr  = ReqAddr[i*ADDR_BITS +: ADDR_BITS];
        sel_wdata = ReqWrData[i*WIDTH +: WIDTH];
        sel_we    = ReqWrEn[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q    <= StIdle;
      id_q       <= '0;
      BankAddr   <= '0;
      BankWrData <= '0;
      BankWrEn   <= 1'b0;
      RspData    <= '0;
      RspValid   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            BankAddr   <= sel_addr;
            BankWrData <= sel_wdata;
            BankWrEn   <= sel_we;
            id_q       <= winner;
            state_q    <= StAccess;
          end
        end
        StAccess: begin
          // On a write the bank reflects WrData, so this also captures the written word.
          RspData        <= BankRdData;
          BankWrEn       <= 1'b0;
          RspValid[id_q] <= 1'b1;
          state_q        <= StResp;
        end
        StResp: begin
          if (RspReady[id_q]) begin
            RspValid <= '0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
